// File: rtl/addsub_accumulator_pkg.sv
// Shared encodings for the add/subtract accumulator: command codes, FSM states
// and the default datapath width.
package addsub_accumulator_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      CMD_ADD   = 2'b00,
      CMD_SUB   = 2'b01,
      CMD_LOAD  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple adder/subtractor: s = a + (b ^ {WIDTH{op}}) + op,
// built from one full adder per bit.
module addsub_core
   import addsub_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] b_x;

   // Inverting b and injecting op as carry-in gives two's-complement subtract.
   assign b_x      = b ^ {WIDTH{op}};
   assign carry[0] = op;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]       = a[i] ^ b_x[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator stage: accepts one command per handshake, applies it to acc in EXEC
// and holds the result plus flags in RESP until the consumer takes it.
module addsub_accumulator
   import addsub_accumulator_pkg::*;
#(
   parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_cmd,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero,
   output logic [WIDTH-1:0] acc
);

   localparam int unsigned MSB = WIDTH - 1;

   state_e           state_q, state_d;
   cmd_e             cmd_q, cmd_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] core_s;
   logic             core_cout;
   logic             core_op;
   logic [WIDTH-1:0] exec_res;
   logic             exec_carry;
   logic             exec_ovf;

   assign core_op = (cmd_q == CMD_SUB);

   addsub_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a    (acc_q),
      .b    (data_q),
      .op   (core_op),
      .s    (core_s),
      .cout (core_cout)
   );

   // Result and flags for the latched command; only consumed in EXEC.
   always_comb begin
      exec_res   = '0;
      exec_carry = 1'b0;
      exec_ovf   = 1'b0;
      unique case (cmd_q)
         CMD_ADD: begin
            exec_res   = core_s;
            exec_carry = core_cout;
            exec_ovf   = (acc_q[MSB] == data_q[MSB]) && (core_s[MSB] != acc_q[MSB]);
         end
         CMD_SUB: begin
            exec_res   = core_s;
            exec_carry = core_cout;
            exec_ovf   = (acc_q[MSB] != data_q[MSB]) && (core_s[MSB] != acc_q[MSB]);
         end
         CMD_LOAD: begin
            exec_res = data_q;
         end
         CMD_CLEAR: begin
            exec_res = '0;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      data_d    = data_q;
      acc_d     = acc_q;
      result_d  = result_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cmd_d   = cmd_e'(in_cmd);
               data_d  = in_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = exec_res;
            carry_d  = exec_carry;
            ovf_d    = exec_ovf;
            zero_d   = (exec_res == '0);
            acc_d    = exec_res;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cmd_q    <= CMD_ADD;
         data_q   <= '0;
         acc_q    <= ACC_INIT;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         data_q   <= data_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign out_result   = result_q;
   assign out_carry    = carry_q;
   assign out_overflow = ovf_q;
   assign out_zero     = zero_q;
   assign acc          = acc_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Scoreboard bench: the driver pushes model predictions at command acceptance and
// a monitor pops and compares on every completed result handshake.
module tb_addsub_accumulator;

   localparam int W    = 4;
   localparam int MOD  = 1 << W;
   localparam int HALF = MOD / 2;

   localparam int C_ADD   = 0;
   localparam int C_SUB   = 1;
   localparam int C_LOAD  = 2;
   localparam int C_CLEAR = 3;

   typedef struct {
      int result;
      int carry;
      int ovf;
      int zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_cmd = 2'b00;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_result;
   logic         out_carry;
   logic         out_overflow;
   logic         out_zero;
   logic [W-1:0] acc;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   acc_m = 0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];

   addsub_accumulator #(
      .WIDTH    (W),
      .ACC_INIT ('0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_cmd       (in_cmd),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .out_zero     (out_zero),
      .acc          (acc)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out (t=%0t)", nm, $time);
   endtask

   // Reference model: plain integer arithmetic on unsigned/signed views of the operands.
   function automatic exp_t model(input int cmd, input int a, input int d);
      exp_t e;
      int   sa, sd, r, sr;
      sa = (a >= HALF) ? a - MOD : a;
      sd = (d >= HALF) ? d - MOD : d;
      e.carry = 0;
      e.ovf   = 0;
      case (cmd)
         C_ADD: begin
            r       = a + d;
            sr      = sa + sd;
            e.carry = (r >= MOD) ? 1 : 0;
            e.ovf   = (sr >= HALF || sr < -HALF) ? 1 : 0;
         end
         C_SUB: begin
            r       = a - d;
            sr      = sa - sd;
            e.carry = (a >= d) ? 1 : 0;
            e.ovf   = (sr >= HALF || sr < -HALF) ? 1 : 0;
         end
         C_LOAD:  r = d;
         default: r = 0;
      endcase
      e.result = ((r % MOD) + MOD) % MOD;
      e.zero   = (e.result == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic send(input int cmd, input int d);
      int   budget;
      exp_t e;
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         timeout("send_in_ready");
         return;
      end
      in_valid = 1'b1;
      in_cmd   = 2'(cmd);
      in_data  = W'(d);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e = model(cmd, acc_m, d);
      acc_m = e.result;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string nm);
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      if (exp_q.size() != 0) timeout(nm);
   endtask

   // Monitor: a result handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_response: got result %0d, expected no response (t=%0t)",
                     out_result, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_result", int'(out_result), e.result);
            check("out_carry", int'(out_carry), e.carry);
            check("out_overflow", int'(out_overflow), e.ovf);
            check("out_zero", int'(out_zero), e.zero);
            check("acc_at_resp", int'(acc), e.result);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   budget;
      exp_t e;

      // Reset state
      #23;
      check("rst_acc", int'(acc), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_result", int'(out_result), 0);
      check("rst_flags", int'({out_carry, out_overflow, out_zero}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_out_valid", int'(out_valid), 0);

      // Directed arithmetic cases
      out_ready = 1'b1;
      send(C_LOAD, 5);
      send(C_ADD, 3);
      send(C_LOAD, 9);
      send(C_ADD, 7);
      send(C_LOAD, 3);
      send(C_SUB, 5);
      send(C_CLEAR, 11);
      send(C_SUB, 8);
      wait_drain("drain_directed");
      @(negedge clk);
      check("acc_after_directed", int'(acc), 8);

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      send(C_ADD, 6);
      e = exp_q[0];
      budget = 0;
      while (!out_valid && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!out_valid) timeout("bp_out_valid");
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_cmd  = 2'($urandom_range(0, 3));
         in_data = W'($urandom_range(0, MOD - 1));
         @(negedge clk);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_result", int'(out_result), e.result);
         check("bp_flags", int'({out_carry, out_overflow, out_zero}),
               e.carry * 4 + e.ovf * 2 + e.zero);
         check("bp_acc", int'(acc), e.result);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", int'(out_valid), 0);
      check("bp_release_in_ready", int'(in_ready), 1);
      wait_drain("drain_bp");

      // Randomised traffic with random consumer stalls
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)));
      end
      wait_drain("drain_random");
      rand_ready = 1'b0;
      #3;
      out_ready = 1'b1;
      @(negedge clk);
      check("acc_after_random", int'(acc), acc_m);

      // Reset during EXEC discards the command
      send(C_LOAD, 4);
      wait_drain("drain_pre_reset");
      send(C_ADD, 2);
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check("midrst_acc", int'(acc), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      acc_m = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_out_valid", int'(out_valid), 0);
      end
      check("post_rst_acc", int'(acc), 0);
      check("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
